// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, req/ack data-memory access FSM and MEM/WB register.
// Define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES cycles without an ack.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_res,
  input  logic [31:0] WriteData,
  input  logic [4:0]  rd,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemToReg,
  output logic [31:0] alu_res_mem,
  output logic [4:0]  rd_mem,
  output logic        RegWrite_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWrite,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [31:0] aluRes_q, writeData_q;
  logic [4:0]  rd_q;
  logic        memRead_q, memWrite_q, regWrite_q, memToReg_q;
  logic [31:0] wbData_q, wbData_d;
  logic [4:0]  wbRd_q, wbRd_d;
  logic        wbRegWrite_q, wbRegWrite_d;
  logic        inAccess, timeout;

  assign inAccess = (state_q == ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] waitCnt_q;

  assign timeout = inAccess && !dmem_ack && (waitCnt_q == CW'(TIMEOUT_CYCLES));
  assign mem_err = timeout;

  // Counts ACCESS cycles spent without an ack; any other cycle restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt_q <= '0;
    end else if (inAccess && !dmem_ack && !timeout) begin
      waitCnt_q <= waitCnt_q + 1'b1;
    end else begin
      waitCnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign mem_stall = inAccess && !dmem_ack && !timeout;

  // A timed-out access retires as a bubble; loads only take rdata when really loading.
  always_comb begin
    state_d      = state_q;
    wbData_d     = wbData_q;
    wbRd_d       = wbRd_q;
    wbRegWrite_d = 1'b0;
    if (!mem_stall) begin
      state_d = (MemRead || MemWrite) ? ACCESS : IDLE;
      if (!timeout) begin
        wbData_d     = (memToReg_q && memRead_q && !memWrite_q) ? dmem_rdata : aluRes_q;
        wbRd_d       = rd_q;
        wbRegWrite_d = regWrite_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      aluRes_q     <= '0;
      writeData_q  <= '0;
      rd_q         <= '0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      regWrite_q   <= 1'b0;
      memToReg_q   <= 1'b0;
      wbData_q     <= '0;
      wbRd_q       <= '0;
      wbRegWrite_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbData_q     <= wbData_d;
      wbRd_q       <= wbRd_d;
      wbRegWrite_q <= wbRegWrite_d;
      if (!mem_stall) begin
        aluRes_q    <= alu_res;
        writeData_q <= WriteData;
        rd_q        <= rd;
        memRead_q   <= MemRead;
        memWrite_q  <= MemWrite;
        regWrite_q  <= RegWrite;
        memToReg_q  <= MemToReg;
      end
    end
  end

  assign alu_res_mem  = aluRes_q;
  assign rd_mem       = rd_q;
  assign RegWrite_mem = regWrite_q;
  assign dmem_req     = inAccess;
  assign dmem_we      = memWrite_q;
  assign dmem_addr    = {aluRes_q[31:2], 2'b00};
  assign dmem_wdata   = writeData_q;
  assign wb_data      = wbData_q;
  assign wb_rd        = wbRd_q;
  assign wb_RegWrite  = wbRegWrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expected values.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] alu_res, WriteData, dmem_rdata;
  logic [4:0]  rd;
  logic        MemRead, MemWrite, RegWrite, MemToReg, dmem_ack;
  logic [31:0] alu_res_mem, dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  rd_mem, wb_rd;
  logic        RegWrite_mem, dmem_req, dmem_we, mem_stall, wb_RegWrite, mem_err;

  int checkCount = 0;
  int failCount  = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .alu_res(alu_res), .WriteData(WriteData), .rd(rd),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .alu_res_mem(alu_res_mem), .rd_mem(rd_mem), .RegWrite_mem(RegWrite_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                               input logic mr, input logic mw, input logic rw, input logic m2r);
    alu_res = a; WriteData = wd; rd = r;
    MemRead = mr; MemWrite = mw; RegWrite = rw; MemToReg = m2r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    nop();
    tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_wbRegWrite", 32'(wb_RegWrite), 32'd0);
    checkOutput("rst_req",        32'(dmem_req),    32'd0);
    checkOutput("rst_stall",      32'(mem_stall),   32'd0);
    checkOutput("rst_wbData",     wb_data,          32'h0);
    checkOutput("rst_memErr",     32'(mem_err),     32'd0);

    // ALU op retires after two edges
    applyStimulus(32'h5, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("alu_fwdRes", alu_res_mem, 32'h5);
    checkOutput("alu_fwdRd",  32'(rd_mem), 32'd3);
    checkOutput("alu_fwdRw",  32'(RegWrite_mem), 32'd1);
    nop();
    tick();
    checkOutput("alu_wbData", wb_data, 32'h5);
    checkOutput("alu_wbRd",   32'(wb_rd), 32'd3);
    checkOutput("alu_wbRw",   32'(wb_RegWrite), 32'd1);
    checkOutput("alu_req",    32'(dmem_req), 32'd0);
    checkOutput("alu_stall",  32'(mem_stall), 32'd0);

    // Load with three wait cycles; the next ALU op is held upstream
    applyStimulus(32'h103, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(32'h77, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("ld_addr", dmem_addr, 32'h100);
    checkOutput("ld_we",   32'(dmem_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("ld_stall%0d", i), 32'(mem_stall), 32'd1);
      checkOutput($sformatf("ld_hold%0d", i),  alu_res_mem, 32'h103);
      tick();
      checkOutput($sformatf("ld_bubble%0d", i), 32'(wb_RegWrite), 32'd0);
      checkOutput($sformatf("ld_addrHold%0d", i), dmem_addr, 32'h100);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("ld_ackStall", 32'(mem_stall), 32'd0);
    tick();
    dmem_ack = 1'b0;
    checkOutput("ld_wbData", wb_data, 32'hDEADBEEF);
    checkOutput("ld_wbRd",   32'(wb_rd), 32'd4);
    checkOutput("ld_wbRw",   32'(wb_RegWrite), 32'd1);
    checkOutput("ld_nextFwd", alu_res_mem, 32'h77);
    checkOutput("ld_reqDrop", 32'(dmem_req), 32'd0);
    nop();
    tick();
    checkOutput("ld_nextWb", wb_data, 32'h77);

    // Zero-wait store followed by an ALU op
    applyStimulus(32'h40, 32'h12345678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(32'h99, 32'h0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    #1;
    checkOutput("st_req",   32'(dmem_req), 32'd1);
    checkOutput("st_we",    32'(dmem_we), 32'd1);
    checkOutput("st_wdata", dmem_wdata, 32'h12345678);
    checkOutput("st_addr",  dmem_addr, 32'h40);
    checkOutput("st_stall", 32'(mem_stall), 32'd0);
    tick();
    dmem_ack = 1'b0;
    checkOutput("st_reqDrop", 32'(dmem_req), 32'd0);
    checkOutput("st_wbRw",    32'(wb_RegWrite), 32'd0);
    nop();
    tick();
    checkOutput("st_aluWb",   wb_data, 32'h99);
    checkOutput("st_aluRd",   32'(wb_rd), 32'd6);

    // Back-to-back zero-wait loads
    applyStimulus(32'h200, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(32'h204, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'hAAAA0001;
    #1;
    checkOutput("b2b_req1",  32'(dmem_req), 32'd1);
    checkOutput("b2b_addr1", dmem_addr, 32'h200);
    checkOutput("b2b_stall1", 32'(mem_stall), 32'd0);
    tick();
    nop();
    dmem_rdata = 32'hBBBB0002;
    #1;
    checkOutput("b2b_req2",  32'(dmem_req), 32'd1);
    checkOutput("b2b_addr2", dmem_addr, 32'h204);
    checkOutput("b2b_wb1",   wb_data, 32'hAAAA0001);
    checkOutput("b2b_rd1",   32'(wb_rd), 32'd7);
    tick();
    dmem_ack = 1'b0;
    checkOutput("b2b_wb2",    wb_data, 32'hBBBB0002);
    checkOutput("b2b_rd2",    32'(wb_rd), 32'd8);
    checkOutput("b2b_reqEnd", 32'(dmem_req), 32'd0);

    // Reset during ACCESS with a simultaneous ack
    applyStimulus(32'h300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    nop();
    #1;
    checkOutput("rsta_req", 32'(dmem_req), 32'd1);
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    rst = 1'b0; dmem_ack = 1'b0;
    #1;
    checkOutput("rsta_req2",  32'(dmem_req), 32'd0);
    checkOutput("rsta_stall", 32'(mem_stall), 32'd0);
    checkOutput("rsta_wbRw",  32'(wb_RegWrite), 32'd0);
    checkOutput("rsta_wbData", wb_data, 32'h0);

`ifdef MEM_TIMEOUT_EN
    // Unanswered load aborts after four stall cycles
    applyStimulus(32'h500, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(32'h88, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_stall%0d", i), 32'(mem_stall), 32'd1);
      checkOutput($sformatf("to_err%0d", i),   32'(mem_err), 32'd0);
      tick();
    end
    checkOutput("to_stallEnd", 32'(mem_stall), 32'd0);
    checkOutput("to_errPulse", 32'(mem_err), 32'd1);
    tick();
    nop();
    checkOutput("to_errDrop", 32'(mem_err), 32'd0);
    checkOutput("to_wbRw",    32'(wb_RegWrite), 32'd0);
    checkOutput("to_req",     32'(dmem_req), 32'd0);
    checkOutput("to_resume",  alu_res_mem, 32'h88);
`else
    // Without the timeout an unanswered load waits indefinitely
    applyStimulus(32'h500, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    nop();
    for (int i = 0; i < 20; i++) tick();
    checkOutput("wait_stall", 32'(mem_stall), 32'd1);
    checkOutput("wait_err",   32'(mem_err), 32'd0);
    checkOutput("wait_req",   32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF;
    tick();
    dmem_ack = 1'b0;
    checkOutput("wait_wbData", wb_data, 32'h13579BDF);
    checkOutput("wait_wbRd",   32'(wb_rd), 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
